// File: rtl/ysyx_23060187_scoreboard_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060187_scoreboard_regfile_if
//  Brief    : Read/issue/writeback/debug bundle between IDU, WBU and the
//             scoreboarded register file.
//  Revision : 1.0 - initial release
// ============================================================================
interface ysyx_23060187_scoreboard_regfile_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2
);
    // writeback side
    logic                          wen;
    logic [ADDR_WIDTH-1:0]         waddr;
    logic [DATA_WIDTH-1:0]         wdata;
    // read ports, port i at [i*WIDTH +: WIDTH]
    logic [NR_READ*ADDR_WIDTH-1:0] raddr;
    logic [NR_READ*DATA_WIDTH-1:0] rdata;
    logic [NR_READ-1:0]            rbusy;
    // issue handshake
    logic                          issue_valid;
    logic [ADDR_WIDTH-1:0]         issue_rd;
    logic                          issue_ready;
    logic                          flush;
    // debug tap
    logic [ADDR_WIDTH-1:0]         dbg_addr;
    logic [DATA_WIDTH-1:0]         dbg_data;

    // pipeline side
    modport master (
        output wen, waddr, wdata, raddr, issue_valid, issue_rd, flush, dbg_addr,
        input  rdata, rbusy, issue_ready, dbg_data
    );

    // register file side
    modport slave (
        input  wen, waddr, wdata, raddr, issue_valid, issue_rd, flush, dbg_addr,
        output rdata, rbusy, issue_ready, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060187_scoreboard_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060187_scoreboard_regfile
//  Brief    : Integer register file with NR_READ combinational read ports,
//             write-to-read bypass, per-register busy scoreboard with an
//             issue/ready handshake, and a non-bypassed debug read port.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060187_scoreboard_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    ysyx_23060187_scoreboard_regfile_if.slave  io_bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_busy_nxt;

    logic w_wr;
    logic w_issue_hit;
    logic w_issue_acc;

    assign w_wr        = io_bus.wen && (io_bus.waddr != '0);
    assign w_issue_hit = io_bus.wen && (io_bus.waddr == io_bus.issue_rd);

    // A register can hold one outstanding producer; a writeback landing this
    // cycle frees it early so back-to-back producers do not bubble.
    always_comb begin
        io_bus.issue_ready = 1'b1;
        if ((io_bus.issue_rd != '0) && r_busy[io_bus.issue_rd] && !w_issue_hit) begin
            io_bus.issue_ready = 1'b0;
        end
    end

    assign w_issue_acc = io_bus.issue_valid && io_bus.issue_ready && (io_bus.issue_rd != '0);

    // Next busy vector: writeback clears, accepted issue sets (new producer
    // wins over a same-cycle writeback), flush clears everything last.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr) begin
            w_busy_nxt[io_bus.waddr] = 1'b0;
        end
        if (w_issue_acc) begin
            w_busy_nxt[io_bus.issue_rd] = 1'b1;
        end
        if (io_bus.flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Register storage and scoreboard state; reset wipes both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr) begin
                r_rf[io_bus.waddr] <= io_bus.wdata;
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports with same-cycle bypass from the writeback bus.
    for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;
        logic                  w_rb;

        assign w_ra = io_bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        // Select zero / bypass / stored value for this port.
        always_comb begin
            w_rd = r_rf[w_ra];
            w_rb = r_busy[w_ra];
            if (w_ra == '0) begin
                w_rd = '0;
                w_rb = 1'b0;
            end else if (io_bus.wen && (io_bus.waddr == w_ra)) begin
                w_rd = io_bus.wdata;
                w_rb = 1'b0;
            end
        end

        assign io_bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        assign io_bus.rbusy[gi]                          = w_rb;
    end

    // Debug tap shows committed state only.
    assign io_bus.dbg_data = r_rf[io_bus.dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060187_scoreboard_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060187_scoreboard_regfile
//  Brief    : Self-checking bench: directed vector table, reset/async-reset
//             sequences and randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060187_scoreboard_regfile;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic clk;
    logic rst_n;

    ysyx_23060187_scoreboard_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) bus ();

    ysyx_23060187_scoreboard_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench-driven inputs
    logic          d_wen;
    logic [AW-1:0] d_waddr;
    logic [DW-1:0] d_wdata;
    logic [AW-1:0] d_ra0, d_ra1;
    logic          d_iv;
    logic [AW-1:0] d_ird;
    logic          d_fl;
    logic [AW-1:0] d_dbg;

    assign bus.wen         = d_wen;
    assign bus.waddr       = d_waddr;
    assign bus.wdata       = d_wdata;
    assign bus.raddr       = {d_ra1, d_ra0};
    assign bus.issue_valid = d_iv;
    assign bus.issue_rd    = d_ird;
    assign bus.flush       = d_fl;
    assign bus.dbg_addr    = d_dbg;

    int total = 0;
    int bad   = 0;

    // reference model: committed values and outstanding-producer flags
    logic [DW-1:0] mrf   [32];
    logic          mbusy [32];

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra0, ra1;
        logic          iv;
        logic [AW-1:0] ird;
        logic          fl;
        logic [AW-1:0] dbg;
        logic [DW-1:0] e_rd0, e_rd1;
        logic [1:0]    e_rbusy;
        logic          e_ready;
        logic [DW-1:0] e_dbg;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
        if (d_wen && d_waddr == ra) return d_wdata;
        return mrf[ra];
    endfunction

    function automatic logic m_rb(input logic [AW-1:0] ra);
        if (ra == 0) return 1'b0;
        if (d_wen && d_waddr == ra) return 1'b0;
        return mbusy[ra];
    endfunction

    function automatic logic m_ready();
        return (d_ird == 0) || !mbusy[d_ird] || (d_wen && d_waddr == d_ird);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mrf[i]   = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        d_wen = 0; d_waddr = 0; d_wdata = 0; d_ra0 = 0; d_ra1 = 0;
        d_iv = 0; d_ird = 0; d_fl = 0; d_dbg = 0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic rdy;
        rdy = m_ready();
        @(posedge clk);
        if (d_wen && d_waddr != 0) begin
            mrf[d_waddr]   = d_wdata;
            mbusy[d_waddr] = 1'b0;
        end
        if (d_iv && rdy && d_ird != 0) mbusy[d_ird] = 1'b1;
        if (d_fl) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rdata0"}, bus.rdata[DW-1:0], m_rd(d_ra0));
        chk({tag, "_rdata1"}, bus.rdata[2*DW-1:DW], m_rd(d_ra1));
        chk({tag, "_rbusy"}, {30'd0, bus.rbusy}, {30'd0, m_rb(d_ra1), m_rb(d_ra0)});
        chk({tag, "_ready"}, {31'd0, bus.issue_ready}, {31'd0, m_ready()});
        chk({tag, "_dbg"}, bus.dbg_data, mrf[d_dbg]);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,       2'b00, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 5'd0, 32'h00001234, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,       2'b00, 1'b1, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,       2'b00, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00, 1'b1, 32'hA5A5A5A5};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b0, 5'd3, 1'b0, 5'd3, 32'h0,        32'hA5A5A5A5, 2'b01, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 5'd3, 32'h00000055, 5'd3, 5'd7, 1'b0, 5'd3, 1'b0, 5'd3, 32'h55,       32'hA5A5A5A5, 2'b00, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b0, 5'd3, 1'b0, 5'd3, 32'h55,       32'hA5A5A5A5, 2'b00, 1'b1, 32'h55};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd3, 1'b1, 5'd4, 1'b0, 5'd4, 32'h0,        32'h55,       2'b00, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 5'd4, 32'h00000099, 5'd4, 5'd4, 1'b1, 5'd4, 1'b0, 5'd4, 32'h99,       32'h99,       2'b00, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd3, 1'b0, 5'd4, 1'b0, 5'd4, 32'h99,       32'h55,       2'b01, 1'b0, 32'h99};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd6, 1'b1, 5'd6, 1'b1, 5'd6, 32'h99,       32'h0,        2'b01, 1'b1, 32'h0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd6, 1'b0, 5'd4, 1'b0, 5'd4, 32'h99,       32'h0,        2'b00, 1'b1, 32'h99};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        5'd6, 5'd6, 1'b0, 5'd6, 1'b0, 5'd6, 32'h0,        32'h0,        2'b00, 1'b1, 32'h0};

        model_clear();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // post-reset sweep: every register reads zero and nothing is busy
        for (int i = 0; i < 32; i++) begin
            d_dbg = AW'(i); d_ird = AW'(i); d_ra0 = AW'(i); d_ra1 = AW'(31 - i);
            #1;
            chk("reset_dbg", bus.dbg_data, 32'h0);
            chk("reset_ready", {31'd0, bus.issue_ready}, 32'd1);
            chk("reset_rbusy", {30'd0, bus.rbusy}, 32'd0);
        end
        idle();

        // directed vector table
        for (int v = 0; v < 14; v++) begin
            d_wen = tbl[v].wen; d_waddr = tbl[v].waddr; d_wdata = tbl[v].wdata;
            d_ra0 = tbl[v].ra0; d_ra1 = tbl[v].ra1; d_iv = tbl[v].iv;
            d_ird = tbl[v].ird; d_fl = tbl[v].fl; d_dbg = tbl[v].dbg;
            @(negedge clk);
            chk($sformatf("vec%0d_rdata0", v), bus.rdata[DW-1:0], tbl[v].e_rd0);
            chk($sformatf("vec%0d_rdata1", v), bus.rdata[2*DW-1:DW], tbl[v].e_rd1);
            chk($sformatf("vec%0d_rbusy", v), {30'd0, bus.rbusy}, {30'd0, tbl[v].e_rbusy});
            chk($sformatf("vec%0d_ready", v), {31'd0, bus.issue_ready}, {31'd0, tbl[v].e_ready});
            chk($sformatf("vec%0d_dbg", v), bus.dbg_data, tbl[v].e_dbg);
            tick();
        end
        idle();

        // async reset mid-operation: x9 written, then x9 and x10 made busy
        d_wen = 1; d_waddr = 9; d_wdata = 32'h77;
        tick();
        idle(); d_iv = 1; d_ird = 9;
        tick();
        d_ird = 10;
        tick();
        idle(); d_ra0 = 9; d_ra1 = 10; d_dbg = 9; d_ird = 9;
        #1;
        chk("pre_rst_rbusy", {30'd0, bus.rbusy}, 32'd3);
        chk("pre_rst_dbg", bus.dbg_data, 32'h77);
        chk("pre_rst_ready", {31'd0, bus.issue_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("in_rst_dbg", bus.dbg_data, 32'h0);
        chk("in_rst_rbusy", {30'd0, bus.rbusy}, 32'd0);
        chk("in_rst_ready", {31'd0, bus.issue_ready}, 32'd1);
        chk("in_rst_rdata0", bus.rdata[DW-1:0], 32'h0);
        // writes during reset are ignored but still bypass combinationally
        d_wen = 1; d_waddr = 9; d_wdata = 32'hFF; d_iv = 1; d_ird = 10;
        #1;
        chk("in_rst_bypass", bus.rdata[DW-1:0], 32'hFF);
        @(posedge clk);
        #1;
        idle(); d_ra0 = 9; d_ra1 = 10; d_dbg = 9;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
        chk("post_rst_dbg9", bus.dbg_data, 32'h0);
        chk("post_rst_rbusy", {30'd0, bus.rbusy}, 32'd0);
        d_ird = 9;
        #1;
        chk("post_rst_ready9", {31'd0, bus.issue_ready}, 32'd1);
        d_ird = 10;
        #1;
        chk("post_rst_ready10", {31'd0, bus.issue_ready}, 32'd1);
        @(posedge clk);
        #1;

        // randomized traffic over a narrow index range to force collisions
        for (int n = 0; n < 400; n++) begin
            d_wen   = ($urandom_range(0, 2) != 0);
            d_waddr = AW'($urandom_range(0, 7));
            d_wdata = $urandom;
            d_ra0   = AW'($urandom_range(0, 7));
            d_ra1   = AW'($urandom_range(0, 7));
            d_iv    = ($urandom_range(0, 1) != 0);
            d_ird   = AW'($urandom_range(0, 7));
            d_fl    = ($urandom_range(0, 15) == 0);
            d_dbg   = AW'($urandom_range(0, 7));
            @(negedge clk);
            check_model("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060187_scoreboard_regfile.md
# ysyx_23060187_scoreboard_regfile

Parametrised integer register file for the NPC core with N combinational read ports and write-to-read bypass. It carries a per-register busy scoreboard, with an issue/ready handshake, so the decode stage can detect RAW and WAW hazards against in-flight writebacks. It also has a debug read port for difftest/trap inspection. It sits between IDU (read/issue) and WBU (writeback), and replaces the fixed two-port file that has hard-wired GPR taps.

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NR_READ, 2, number of read ports (1..4)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  1  writeback valid
- waddr  in  ADDR_WIDTH  writeback index
- wdata  in  DATA_WIDTH  writeback data
- raddr  in  NR_READ*ADDR_WIDTH  read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NR_READ*DATA_WIDTH  read data, same packing
- rbusy  out  NR_READ  port i source has pending writeback
- issue_valid  in  1  IDU issues an instruction that writes issue_rd
- issue_rd  in  ADDR_WIDTH  destination of issued instruction
- issue_ready  out  1  issue accepted when issue_valid && issue_ready
- flush  in  1  synchronous clear of all busy bits (pipeline flush)
- dbg_addr  in  ADDR_WIDTH  debug read index
- dbg_data  out  DATA_WIDTH  debug read data, no bypass

## Operation
- Storage: 2**ADDR_WIDTH registers plus a busy bit per register. Register 0 reads 0 at all times and its busy bit is always 0.
- Write: on a clk edge with wen && waddr!=0, rf[waddr] <= wdata and busy[waddr] <= 0, unless the same edge sets it again (see below).
- Read port i, combinational:
  - raddr_i==0 -> rdata 0, rbusy 0.
  - Else if wen && waddr==raddr_i -> rdata = wdata (bypass), rbusy = 0.
  - Else rdata = rf[raddr_i], rbusy = busy[raddr_i].
- issue_ready = 1 if issue_rd==0, or !busy[issue_rd], or (wen && waddr==issue_rd). A single bit per register means at most one outstanding producer; WAW against a pending writeback stalls.
- Issue accept (issue_valid && issue_ready && issue_rd!=0) sets busy[issue_rd] at the edge.
- Same-edge writeback and accepted issue to the same rd: data is written and busy ends at 1 (the new producer wins).
- flush=1 clears every busy bit at the edge and overrides an accepted issue in the same cycle. Register contents are unaffected, and a same-cycle writeback still writes.
- Debug port: dbg_data = rf[dbg_addr] (0 for index 0). It reflects only committed state and never bypasses.
- Issue with issue_rd==0 is accepted and has no effect.

## Timing
- Reads, bypass, rbusy, issue_ready: zero latency, combinational from inputs and state.
- Writes, busy set/clear, flush: take effect at the rising clk edge and are visible to reads and dbg the following cycle (bypass covers the same cycle).
- Reset: rst_n low asynchronously clears all registers and all busy bits. Outputs while in reset:
  - rdata = bypass value if wen matches, else 0.
  - rbusy = 0.
  - issue_ready = 1.
  - dbg_data = 0.
- Writes and issues are ignored while rst_n is low. Reset is released synchronously by the environment.
- Reset asserted mid-operation drops all pending busy state; no writeback is required to clear it.

## Test plan
- Reset: rst_n=0, then 1. All 32 dbg reads return 0, rbusy all 0, issue_ready=1 for every issue_rd.
- Write/read/x0: write 0xDEADBEEF to x5 and 0x1234 to x0. Next cycle raddr0=5 -> 0xDEADBEEF, raddr1=0 -> 0, dbg x0 -> 0.
- Bypass: wen, waddr=7, wdata=0xA5A5A5A5 with raddr0=raddr1=7 in the same cycle. rdata both 0xA5A5A5A5, rbusy 0, and dbg_data at x7 still shows the old value that cycle.
- Scoreboard:
  - Issue rd=3, then next cycle raddr0=3 -> rbusy0=1 and issue_ready for rd=3 is 0.
  - Writeback x3=0x55 -> same cycle rbusy0=0, rdata0=0x55, issue_ready=1.
  - Next cycle rbusy0=0.
- Simultaneous events: busy x4 pending; writeback x4=0x99 with an accepted issue rd=4 in the same cycle. Next cycle rf[4]=0x99, busy[4]=1. Then flush together with issue rd=6 -> all busy 0, including x6.
- Async reset mid-op: busy x9 and x10 set, x9=0x77, and rst_n pulsed low between edges. Immediately dbg x9=0, all rbusy 0; after release, issue_ready=1 for x9 and x10.
